spi_reg_ctrl: RTL and testbench
===============================

# spi_reg_ctrl

Command sequencer behind the SPI byte shifter. It turns the received byte stream of one chip-select frame into register-bank accesses: byte 0 is a command (direction plus start address), and every following byte is write data or a read slot. Addresses auto-increment. It sits between the byte-level SPI slave (MOSI/MISO/SCLK handling on the internal 48 MHz clock) and the register bank, and supplies the byte shifted out on MISO.

## Interface
- ADDR_W, 7: register address width. The command byte carries the address in bits [ADDR_W-1:0]; ADDR_W ≤ 7.
- IDLE_TX, 8'h00: byte presented on tx_byte outside read data.
- clk in 1: internal 48 MHz oscillator clock; all logic on rising edge.
- rst_n in 1: reset is asynchronous and active-low.
- cs_n in 1: chip select, already synchronized to clk; low = frame active.
- rx_valid in 1: one-cycle strobe from byte shifter, 8 bits received.
- rx_byte in 8: received byte, valid with rx_valid.
- tx_byte out 8: byte the shifter loads for the next transfer; registered.
- reg_addr out ADDR_W: register address.
- reg_wdata out 8: write data.
- reg_we out 1: one-cycle write strobe.
- reg_re out 1: one-cycle read strobe; reg_rdata must be valid the following cycle.
- reg_rdata in 8: read data from the bank.
- busy out 1: high while a frame is active (state ≠ IDLE).
- err out 1: sticky spacing-violation flag.

## Operation
- Reset values: tx_byte=IDLE_TX, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, busy=0, err=0, state=IDLE.
- States: IDLE, CMD, WRITE, RFETCH, READ.
- IDLE → CMD when cs_n is low. Entering CMD clears err and sets tx_byte=IDLE_TX.
- CMD, on rx_valid:
  - Set reg_addr = rx_byte[ADDR_W-1:0].
  - rx_byte[7]=0 → WRITE.
  - rx_byte[7]=1 → pulse reg_re and go to RFETCH.
- WRITE, on rx_valid:
  - Pulse reg_we with reg_wdata=rx_byte at the current reg_addr.
  - The next cycle, reg_addr increments.
  - tx_byte = rx_byte (echo).
- RFETCH: one cycle. Latch tx_byte=reg_rdata → READ.
- READ, on rx_valid:
  - reg_addr increments.
  - Pulse reg_re at the new address the cycle after.
  - Go to RFETCH. rx_byte is ignored.
- Address arithmetic is modulo 2^ADDR_W: 0x7F+1 → 0x00 for ADDR_W=7.
- cs_n high in any state → IDLE at the next edge:
  - reg_we/reg_re are forced 0 that cycle.
  - tx_byte returns to IDLE_TX.
  - err holds its value.
- rx_valid in the same cycle as cs_n high is dropped: no access.
- A partial byte never produces rx_valid, so it is never committed.
- rx_valid while in RFETCH, or within 2 cycles of the previous rx_valid, sets err. That byte is still processed per the current state.

## Timing
- Write: reg_we is asserted in the cycle after rx_valid (registered). That is 1-cycle latency byte → bank.
- Read:
  - Command rx_valid at cycle N → reg_re at N+1 → tx_byte valid at N+3.
  - Each subsequent read byte follows the same pipeline.
- The byte shifter needs tx_byte ≥ 3 clk cycles after rx_valid. SCLK ≤ 6 MHz gives ≥ 8 clk cycles per bit, so this is satisfied.
- reg_addr is stable whenever reg_we/reg_re is high.
- busy updates one cycle after cs_n changes.

## Structure
- Shared package spi_ctrl_pkg holds:
  - state enum;
  - CMD_RD_BIT = 7;
  - default IDLE_TX;
  - minimum rx_valid spacing (3).
- Single module; no sub-module. The FSM and address counter are small enough to keep inline.

## Test plan
- Write burst: cs_n low, bytes 0x05, 0x11, 0x22, cs_n high → reg_we at addr 0x05 data 0x11, then addr 0x06 data 0x22. tx_byte echoes 0x11, 0x22; back to IDLE with tx_byte=0x00.
- Read burst: bank[0x10]=0xAB, bank[0x11]=0xCD; bytes 0x90, 0x00, 0x00 → reg_re at 0x10, 0x11, 0x12. tx_byte=0xAB within 3 cycles of the first rx_valid, then 0xCD.
- Wrap: write command 0x7F, data 0x01, 0x02 → writes at 0x7F then 0x00.
- Abort: cs_n high in the same cycle as the second data rx_valid → no reg_we for that byte. busy=0 next cycle. The next frame starts in CMD.
- Spacing violation: two rx_valid pulses 1 cycle apart → err=1 and remains 1 after cs_n high. It clears on the next frame start.
- Async reset: assert rst_n low mid-read-burst (no clk edge needed) → all outputs reach their reset values immediately.

Source files
------------

// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI command sequencer: FSM states and frame constants.
package spi_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_WRITE  = 3'd2,
    ST_RFETCH = 3'd3,
    ST_READ   = 3'd4
  } state_e;

  // Command byte bit selecting read (1) or write (0)
  localparam int unsigned CMD_RD_BIT      = 7;
  // Byte shifted out on MISO whenever no read data is pending
  localparam logic [7:0]  IDLE_TX_DEFAULT = 8'h00;
  // Minimum clk cycles between two rx_valid strobes
  localparam int unsigned MIN_RX_SPACING  = 3;

endpackage

// File: rtl/spi_reg_ctrl.sv
// Command sequencer behind the SPI byte shifter: turns one chip-select frame
// (command byte + data/read slots) into auto-incrementing register accesses.
module spi_reg_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = 7,
  parameter logic [7:0]  IDLE_TX = IDLE_TX_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic [7:0]        tx_byte,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic              busy,
  output logic              err
);

  // Spacing counter saturates here; a strobe seen below this value is too early
  localparam logic [1:0]        GAP_MAX  = 2'(MIN_RX_SPACING - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [7:0]        tx_q, tx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              re_q, re_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              inc_q, inc_d;    // address bump owed after a write strobe
  logic              pend_q, pend_d;  // read strobe owed after a read-slot bump
  logic [1:0]        gap_q, gap_d;    // cycles since last rx_valid (saturating)

  // State and all registered outputs, asynchronously cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tx_q    <= IDLE_TX;
      addr_q  <= '0;
      wdata_q <= 8'h00;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      inc_q   <= 1'b0;
      pend_q  <= 1'b0;
      gap_q   <= GAP_MAX;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      re_q    <= re_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      inc_q   <= inc_d;
      pend_q  <= pend_d;
      gap_q   <= gap_d;
    end
  end

  // Next-state: chip select high always returns to IDLE; RFETCH waits for the
  // owed strobe and the bank's one-cycle read latency before presenting data
  always_comb begin
    state_d = state_q;
    if (cs_n) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   state_d = ST_CMD;
        ST_CMD: begin
          if (rx_valid) begin
            state_d = rx_byte[CMD_RD_BIT] ? ST_RFETCH : ST_WRITE;
          end else begin
            state_d = ST_CMD;
          end
        end
        ST_WRITE:  state_d = ST_WRITE;
        ST_RFETCH: begin
          if (!pend_q && !re_q) begin
            state_d = ST_READ;
          end else begin
            state_d = ST_RFETCH;
          end
        end
        ST_READ: begin
          if (rx_valid) begin
            state_d = ST_RFETCH;
          end else begin
            state_d = ST_READ;
          end
        end
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Output/datapath next values: strobes, address counter, MISO byte, error flag
  always_comb begin
    tx_d    = tx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    err_d   = err_q;
    inc_d   = 1'b0;
    pend_d  = 1'b0;
    busy_d  = (state_d != ST_IDLE);

    if (cs_n) begin
      // Frame ended or aborted: drop any strobe, keep err for software to see
      tx_d = IDLE_TX;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tx_d  = IDLE_TX;
          err_d = 1'b0;
        end
        ST_CMD: begin
          if (rx_valid) begin
            addr_d = rx_byte[ADDR_W-1:0];
            re_d   = rx_byte[CMD_RD_BIT];
          end else begin
            addr_d = addr_q;
          end
        end
        ST_WRITE: begin
          // Bump after the strobe cycle so reg_addr is stable while reg_we is high
          if (inc_q) begin
            addr_d = addr_q + ADDR_ONE;
          end else begin
            addr_d = addr_q;
          end
          if (rx_valid) begin
            we_d    = 1'b1;
            wdata_d = rx_byte;
            tx_d    = rx_byte;
            inc_d   = 1'b1;
          end else begin
            we_d    = 1'b0;
          end
        end
        ST_RFETCH: begin
          if (pend_q) begin
            re_d = 1'b1;
          end else if (!re_q) begin
            tx_d = reg_rdata;
          end else begin
            tx_d = tx_q;
          end
        end
        ST_READ: begin
          if (rx_valid) begin
            addr_d = addr_q + ADDR_ONE;
            pend_d = 1'b1;
          end else begin
            addr_d = addr_q;
          end
        end
        default: begin
          tx_d = IDLE_TX;
        end
      endcase

      if (rx_valid && (state_q != ST_IDLE) &&
          ((state_q == ST_RFETCH) || (gap_q != GAP_MAX))) begin
        err_d = 1'b1;
      end else begin
        err_d = (state_q == ST_IDLE) ? 1'b0 : err_q;
      end
    end
  end

  // Strobe-spacing counter, restarted at every frame boundary
  always_comb begin
    if (cs_n || (state_q == ST_IDLE)) begin
      gap_d = GAP_MAX;
    end else if (rx_valid) begin
      gap_d = 2'd0;
    end else if (gap_q != GAP_MAX) begin
      gap_d = gap_q + 2'd1;
    end else begin
      gap_d = gap_q;
    end
  end

  assign tx_byte   = tx_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_we    = we_q;
  assign reg_re    = re_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl: a behavioural register bank plus a
// frame-level reference model that predicts accesses and MISO bytes.
module tb_spi_reg_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cs_n;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic [7:0] tx_byte;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       busy;
  logic       err;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  bank    [128];  // register bank seen by the DUT
  logic [7:0]  ref_mem [128];  // model's view of what the bank should hold
  logic [14:0] wr_log[$], exp_wr[$];
  logic [6:0]  rd_log[$], exp_rd[$];
  logic [7:0]  fb [16];

  spi_reg_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .tx_byte(tx_byte), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
    .reg_re(reg_re), .reg_rdata(reg_rdata), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Bank: one-cycle read latency, write on strobe
  always @(posedge clk) begin
    if (reg_re) reg_rdata <= bank[reg_addr];
    if (reg_we) bank[reg_addr] <= reg_wdata;
  end

  // Access logger, sampled away from the active edge
  always @(negedge clk) begin
    if (reg_we) wr_log.push_back({reg_addr, reg_wdata});
    if (reg_re) rd_log.push_back(reg_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic clear_logs();
    wr_log.delete(); rd_log.delete(); exp_wr.delete(); exp_rd.delete();
  endtask

  task automatic compare_logs(input string tag);
    chk({tag, "_wr_count"}, wr_log.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++)
      chk({tag, "_wr_entry"}, {17'd0, wr_log[i]}, {17'd0, exp_wr[i]});
    chk({tag, "_rd_count"}, rd_log.size(), exp_rd.size());
    for (int i = 0; i < exp_rd.size() && i < rd_log.size(); i++)
      chk({tag, "_rd_entry"}, {25'd0, rd_log[i]}, {25'd0, exp_rd[i]});
  endtask

  // One complete frame: fb[0] is the command, fb[1..n-1] data/read slots
  task automatic run_frame(input string tag, input int n);
    logic [6:0] a;
    logic       rd;
    clear_logs();
    a  = fb[0][6:0];
    rd = fb[0][7];
    cs_n = 1'b0;
    repeat (3) @(negedge clk);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    send_byte(fb[0]);
    if (rd) exp_rd.push_back(a);
    @(negedge clk);
    if (rd) chk({tag, "_rd_lat2"}, {24'd0, tx_byte}, 32'h00);
    @(negedge clk);
    if (rd) chk({tag, "_rd_lat3"}, {24'd0, tx_byte}, {24'd0, ref_mem[a]});
    repeat (6) @(negedge clk);
    if (!rd) chk({tag, "_cmd_tx"}, {24'd0, tx_byte}, 32'h00);
    for (int i = 1; i < n; i++) begin
      logic [6:0] ai;
      ai = a + 7'(i);
      if (rd) begin
        exp_rd.push_back(ai);
      end else begin
        ai = a + 7'(i - 1);
        exp_wr.push_back({ai, fb[i]});
        ref_mem[ai] = fb[i];
      end
      send_byte(fb[i]);
      repeat (8) @(negedge clk);
      if (rd) chk({tag, "_rd_tx"}, {24'd0, tx_byte}, {24'd0, ref_mem[ai]});
      else    chk({tag, "_wr_echo"}, {24'd0, tx_byte}, {24'd0, fb[i]});
    end
    chk({tag, "_err_clean"}, {31'd0, err}, 32'd0);
    cs_n = 1'b1;
    repeat (2) @(negedge clk);
    chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    chk({tag, "_tx_end"}, {24'd0, tx_byte}, 32'h00);
    compare_logs(tag);
  endtask

  initial begin
    rst_n = 1'b0; cs_n = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00; reg_rdata = 8'h00;
    for (int i = 0; i < 128; i++) begin
      bank[i]    = 8'($urandom);
      ref_mem[i] = bank[i];
    end
    repeat (3) @(negedge clk);
    chk("rst_tx", {24'd0, tx_byte}, 32'h00);
    chk("rst_addr", {25'd0, reg_addr}, 32'h00);
    chk("rst_wdata", {24'd0, reg_wdata}, 32'h00);
    chk("rst_strobes", {30'd0, reg_we, reg_re}, 32'd0);
    chk("rst_busy_err", {30'd0, busy, err}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Write burst
    fb[0] = 8'h05; fb[1] = 8'h11; fb[2] = 8'h22;
    run_frame("wburst", 3);

    // Read burst over freshly written locations
    fb[0] = 8'h10; fb[1] = 8'hAB; fb[2] = 8'hCD;
    run_frame("rprep", 3);
    fb[0] = 8'h90; fb[1] = 8'h00; fb[2] = 8'h00;
    run_frame("rburst", 3);

    // Address wrap on write and read
    fb[0] = 8'h7F; fb[1] = 8'h01; fb[2] = 8'h02;
    run_frame("wwrap", 3);
    fb[0] = 8'hFF; fb[1] = 8'h00; fb[2] = 8'h00;
    run_frame("rwrap", 3);

    // Abort: cs_n rises together with the second data strobe
    clear_logs();
    cs_n = 1'b0;
    repeat (3) @(negedge clk);
    send_byte(8'h20);
    repeat (8) @(negedge clk);
    send_byte(8'h33);
    exp_wr.push_back({7'h20, 8'h33});
    ref_mem[7'h20] = 8'h33;
    repeat (8) @(negedge clk);
    cs_n = 1'b1;
    send_byte(8'h44);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_tx", {24'd0, tx_byte}, 32'h00);
    repeat (3) @(negedge clk);
    compare_logs("abort");
    fb[0] = 8'h21; fb[1] = 8'h55;
    run_frame("after_abort", 2);

    // Spacing violation: strobes two cycles apart
    clear_logs();
    cs_n = 1'b0;
    repeat (3) @(negedge clk);
    send_byte(8'h30);
    repeat (8) @(negedge clk);
    send_byte(8'h01);
    @(negedge clk);
    send_byte(8'h02);
    exp_wr.push_back({7'h30, 8'h01}); ref_mem[7'h30] = 8'h01;
    exp_wr.push_back({7'h31, 8'h02}); ref_mem[7'h31] = 8'h02;
    repeat (8) @(negedge clk);
    chk("space_err", {31'd0, err}, 32'd1);
    cs_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("space_err_held", {31'd0, err}, 32'd1);
    compare_logs("space");
    cs_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("space_err_clear", {31'd0, err}, 32'd0);
    cs_n = 1'b1;
    repeat (3) @(negedge clk);

    // Randomized frames against the model
    for (int f = 0; f < 8; f++) begin
      int n;
      n = $urandom_range(2, 6);
      fb[0] = {1'($urandom), (f == 0) ? 7'h7D : 7'($urandom)};
      for (int i = 1; i < n; i++) fb[i] = 8'($urandom);
      run_frame("rand", n);
    end

    // Asynchronous reset in the middle of a read burst
    cs_n = 1'b0;
    repeat (3) @(negedge clk);
    send_byte(8'h90);
    repeat (4) @(negedge clk);
    chk("pre_rst_tx", {24'd0, tx_byte}, {24'd0, ref_mem[7'h10]});
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tx", {24'd0, tx_byte}, 32'h00);
    chk("arst_addr", {25'd0, reg_addr}, 32'h00);
    chk("arst_wdata", {24'd0, reg_wdata}, 32'h00);
    chk("arst_strobes", {30'd0, reg_we, reg_re}, 32'd0);
    chk("arst_busy_err", {30'd0, busy, err}, 32'd0);
    cs_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
